// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that time-shares one enabled 4:1 mux among four requesters,
// with a programmable per-ownership hold limit and direct handoff on release.

module mux4to1En (
   input  logic [3:0] y,
   input  logic [1:0] s,
   input  logic       En,
   output logic       o
);

   assign o = En ? y[s] : 1'b0;

endmodule

module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CW       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] y,
   output logic [3:0] gnt,
   output logic [1:0] s,
   output logic       En,
   output logic       o,
   output logic       busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_nxt;
   logic [1:0]      owner, owner_nxt;
   logic [1:0]      ptr, ptr_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [1:0]      pick_idx;
   logic            rel;

   // First set bit of vec scanning upward from base, wrapping 3 -> 0.
   function automatic logic [1:0] pick(input logic [3:0] vec, input logic [1:0] base);
      logic [1:0] idx;
      logic [1:0] result;
      result = base;
      for (int k = 3; k >= 0; k--) begin
         idx = base + 2'(k);
         if (vec[idx]) result = idx;
      end
      return result;
   endfunction

   assign pick_idx = pick(req, ptr);
   assign rel      = !req[owner] || ((MAX_HOLD != 0) && (cnt == CW'(MAX_HOLD)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= 2'd0;
         ptr   <= 2'd0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req != 4'd0) begin
               state_nxt = GRANT;
               owner_nxt = pick_idx;
               ptr_nxt   = pick_idx + 2'd1;
               cnt_nxt   = CW'(1);
            end
         end
         GRANT: begin
            if (!rel) begin
               if (cnt != {CW{1'b1}}) cnt_nxt = cnt + 1'b1;
            end else if (req != 4'd0) begin
               // ptr already points past the old owner, so it is considered last
               owner_nxt = pick_idx;
               ptr_nxt   = pick_idx + 2'd1;
               cnt_nxt   = CW'(1);
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign En   = (state == GRANT);
   assign busy = En;
   assign s    = owner;
   assign gnt  = En ? (4'b0001 << owner) : 4'b0000;

   mux4to1En u_mux (
      .y  (y),
      .s  (s),
      .En (En),
      .o  (o)
   );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: a behavioural round-robin model checked
// every cycle, plus directed scenarios with literal expectations.

module tb_mux4_rr_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = 4'd0;
   logic [3:0] y   = 4'd0;
   logic [3:0] gnt;
   logic [1:0] s;
   logic       En;
   logic       o;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   bit m_active;
   int m_owner;
   int m_next;
   int m_used;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .y    (y),
      .gnt  (gnt),
      .s    (s),
      .En   (En),
      .o    (o),
      .busy (busy)
   );

   always #5 clk = ~clk;

   function automatic int pickFrom(input logic [3:0] vec, input int start);
      for (int k = 0; k < 4; k++) begin
         if (vec[(start + k) % 4]) return (start + k) % 4;
      end
      return start;
   endfunction

   // Model: owner keeps the mux while requesting and under the hold limit;
   // otherwise the first requester after the previous winner takes over.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_owner  <= 0;
         m_next   <= 0;
         m_used   <= 0;
      end else if (m_active && req[m_owner] && !(MAX_HOLD != 0 && m_used >= MAX_HOLD)) begin
         m_used <= m_used + 1;
      end else if (req != 4'd0) begin
         m_active <= 1'b1;
         m_owner  <= pickFrom(req, m_next);
         m_next   <= (pickFrom(req, m_next) + 1) % 4;
         m_used   <= 1;
      end else begin
         m_active <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
      req = r;
      y   = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("model_gnt",  32'(gnt),  m_active ? 32'(4'b0001 << m_owner) : 32'd0);
         checkOutput("model_s",    32'(s),    32'(m_owner));
         checkOutput("model_En",   32'(En),   32'(m_active));
         checkOutput("model_busy", 32'(busy), 32'(m_active));
         checkOutput("model_o",    32'(o),    m_active ? 32'(y[m_owner]) : 32'd0);
      end
   end

   initial begin
      logic [1:0] hold_seq [12];
      logic [3:0] rot_gnt  [5];
      int prev;

      hold_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
      rot_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset held with everything requesting
      #1;
      rst = 1'b1;
      applyStimulus(4'b1111, 4'b1111);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("reset_gnt", 32'(gnt), 32'd0);
         checkOutput("reset_s",   32'(s),   32'd0);
         checkOutput("reset_En",  32'(En),  32'd0);
         checkOutput("reset_o",   32'(o),   32'd0);
      end
      applyStimulus(4'b0000, 4'b0000);
      rst = 1'b0;
      tick();

      // Single request, one-cycle latency, then drop
      applyStimulus(4'b0100, 4'b0100);
      tick();
      checkOutput("single_gnt", 32'(gnt), 32'h4);
      checkOutput("single_s",   32'(s),   32'd2);
      checkOutput("single_En",  32'(En),  32'd1);
      checkOutput("single_o",   32'(o),   32'd1);
      applyStimulus(4'b0000, 4'b0100);
      tick();
      checkOutput("drop_En", 32'(En), 32'd0);
      checkOutput("drop_o",  32'(o),  32'd0);
      checkOutput("drop_s",  32'(s),  32'd2);

      // Hold limit: two requesters alternate every MAX_HOLD cycles
      applyStimulus(4'b0011, 4'b0001);
      for (int i = 0; i < 12; i++) begin
         tick();
         checkOutput("hold_s",  32'(s),  32'(hold_seq[i]));
         checkOutput("hold_En", 32'(En), 32'd1);
      end
      applyStimulus(4'b0000, 4'b0000);
      tick();
      checkOutput("hold_idle_En", 32'(En), 32'd0);

      // Rotation from ptr = 0: each owner steps aside after one cycle
      rst = 1'b1;
      #1;
      rst = 1'b0;
      applyStimulus(4'b1111, 4'b1010);
      prev = -1;
      for (int i = 0; i < 5; i++) begin
         if (prev >= 0) applyStimulus(4'b1111 & ~(4'b0001 << prev), 4'b1010);
         tick();
         checkOutput("rotate_gnt", 32'(gnt), 32'(rot_gnt[i]));
         prev = int'(s);
      end
      applyStimulus(4'b0000, 4'b0000);
      tick();

      // Sole requester is re-granted at its hold limit with no gap
      applyStimulus(4'b1000, 4'b1000);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("sole_gnt", 32'(gnt), 32'h8);
         checkOutput("sole_o",   32'(o),   32'd1);
      end
      applyStimulus(4'b0000, 4'b0000);
      tick();

      // Asynchronous reset between edges while requester 2 owns the mux
      applyStimulus(4'b0100, 4'b0100);
      tick();
      checkOutput("pre_rst_s",  32'(s),  32'd2);
      checkOutput("pre_rst_En", 32'(En), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("async_gnt",  32'(gnt),  32'd0);
      checkOutput("async_En",   32'(En),   32'd0);
      checkOutput("async_busy", 32'(busy), 32'd0);
      checkOutput("async_o",    32'(o),    32'd0);
      rst = 1'b0;
      applyStimulus(4'b0110, 4'b0010);
      tick();
      checkOutput("post_rst_gnt", 32'(gnt), 32'h2);
      checkOutput("post_rst_o",   32'(o),   32'd1);
      applyStimulus(4'b0000, 4'b0000);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
